symbol_scheduler: RTL and testbench
===================================

SYMBOL_SCHEDULER -- requirements
Module: symbol_scheduler

Interface
REQ-001 Parameter DEPTH, 4, number of request FIFO entries (power of two, 2..16).
REQ-002 Parameter IDLE_SYMBOL, 2'd0, symbol shown when no request is active.
REQ-003 dclk  input  1  pixel clock, 25 MHz; all state on rising edge.
REQ-004 clr  input  1  reset; asynchronous, active-high.
REQ-005 vsync  input  1  active-low vertical sync from the 640x480 timing generator.
REQ-006 req_valid  input  1  requester offers a symbol request.
REQ-007 req_symbol  input  2  symbol code 0..3 to display.
REQ-008 req_frames  input  8  number of frames to hold the symbol; 0 is treated as 1.
REQ-009 req_ready  output  1  FIFO can accept a request this cycle.
REQ-010 flush  input  1  synchronous abort: drops queued requests and the active one.
REQ-011 symbol  output  2  symbol code driven to the display generator.
REQ-012 busy  output  1  high while in SHOW state.
REQ-013 frame_cnt  output  16  count of frame starts since reset.

Function
REQ-014 Frame start is a pulse that is high when vsync_q = 1 and vsync = 0. vsync_q is a register that samples vsync every cycle.
REQ-015 req_ready = (FIFO count < DEPTH), combinational from the registered count.
REQ-016 A push occurs when req_valid && req_ready && !flush and stores {req_symbol, req_frames} at the tail.
REQ-017 A push and a pop in the same cycle leave the count unchanged, and both take effect.
REQ-018 A push to a full FIFO is ignored, the FIFO is unchanged, and no error is flagged.
REQ-019 State machine: IDLE and SHOW. Reset state is IDLE.
REQ-020 In IDLE on frame start with FIFO non-empty:
- pop the head;
- set symbol to the head symbol;
- set hold to max(frames,1)-1;
- go to SHOW.
REQ-021 In IDLE on frame start with FIFO empty: no change.
REQ-022 In SHOW on frame start with hold > 0: decrement hold; symbol is unchanged.
REQ-023 In SHOW on frame start with hold = 0 and FIFO non-empty: pop and load the next entry per REQ-020, staying in SHOW with no idle frame between entries.
REQ-024 In SHOW on frame start with hold = 0 and FIFO empty: symbol = IDLE_SYMBOL and go to IDLE.
REQ-025 The symbol output changes only on the clock edge where frame start is high, i.e. 1 dclk after vsync falls. It never changes mid-frame, except on flush.
REQ-026 A head entry with req_frames = N is displayed for exactly max(N,1) full frames.
REQ-027 On flush, at the next edge:
- FIFO count = 0 and pointers reset;
- state = IDLE;
- symbol = IDLE_SYMBOL;
- hold = 0.
Flush overrides a simultaneous push and a simultaneous frame start.
REQ-028 A push arriving in the same cycle as a frame start with an empty FIFO is not popped until the next frame start.
REQ-029 frame_cnt increments on every frame start and wraps from 65535 to 0. Flush does not affect it.
REQ-030 busy = (state == SHOW).

Reset
REQ-031 While clr is high, all of the following hold immediately and asynchronously:
- symbol = IDLE_SYMBOL;
- busy = 0;
- frame_cnt = 0;
- FIFO empty, so req_ready = 1;
- hold = 0;
- state = IDLE;
- vsync_q = 1.
REQ-032 No frame start is detected in the first cycle after clr deasserts unless vsync is already 0 and vsync_q was 1.
REQ-033 A reset asserted mid-SHOW discards all queued and active requests.

Structure
REQ-034 A shared package holds:
- symbol code constants: SYM_GREEN = 0, SYM_RECT = 1, SYM_RED = 2, SYM_DIAMOND = 3;
- the state encoding;
- the FIFO entry width of 10 bits.
REQ-035 The request FIFO is one sub-module, sym_req_fifo, parameterised by DEPTH and width 10, with the same dclk/clr.
REQ-036 Edge detect, state machine, hold counter and frame counter reside in symbol_scheduler.

Verification
REQ-037 Reset: assert clr mid-frame -> symbol = 0, busy = 0, frame_cnt = 0, req_ready = 1 within the same cycle.
REQ-038 Single request: push {sym = 3, frames = 2} -> symbol = 3 from the first frame start, for exactly 2 frames. symbol = 0 and busy = 0 after the 3rd frame start.
REQ-039 Back-to-back: push {1,1}, {2,0}, {3,3} -> sequence 1, 2, 3, 3, 3, then 0, each change 1 dclk after a vsync fall, with no idle frame between entries.
REQ-040 Full FIFO: push 5 requests with no frame start -> req_ready = 0 after the 4th push, the 5th push is dropped, and the 4 stored entries display in order.
REQ-041 Flush mid-SHOW with 2 entries queued plus a simultaneous push -> next cycle symbol = 0, busy = 0, req_ready = 1, and no entry is ever displayed afterwards.
REQ-042 frame_cnt wrap: force 65535 frame starts -> the next frame start yields frame_cnt = 0.

Source files
------------

// File: rtl/symbol_scheduler_pkg.sv
// Shared definitions for the symbol scheduler: symbol codes, FSM encoding,
// request FIFO entry layout and the hold-counter load helper.
package symbol_scheduler_pkg;

  localparam logic [1:0] SYM_GREEN   = 2'd0;
  localparam logic [1:0] SYM_RECT    = 2'd1;
  localparam logic [1:0] SYM_RED     = 2'd2;
  localparam logic [1:0] SYM_DIAMOND = 2'd3;

  localparam int ENTRY_W = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [1:0] sym;
    logic [7:0] frames;
  } sym_req_t;

  // A request of N frames is shown for max(N,1) frames, so hold counts down to 0.
  function automatic logic [7:0] hold_load(input logic [7:0] frames);
    return (frames == 8'd0) ? 8'd0 : frames - 8'd1;
  endfunction

endpackage

// File: rtl/sym_req_fifo.sv
// Request FIFO for the symbol scheduler. Pushes to a full FIFO and pops from
// an empty one are silently ignored; flush empties it synchronously.
module sym_req_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 10
) (
  input  logic                         dclk,
  input  logic                         clr,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = i_push && !i_flush && (r_count != FULL_CNT);
  assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge dclk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/symbol_scheduler.sv
// Frame-synchronous symbol scheduler: queues symbol requests and shows each
// for its requested number of frames, switching only at vsync falling edges.
module symbol_scheduler
  import symbol_scheduler_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter logic [1:0] IDLE_SYMBOL = SYM_GREEN
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        vsync,
  input  logic        req_valid,
  input  logic [1:0]  req_symbol,
  input  logic [7:0]  req_frames,
  output logic        req_ready,
  input  logic        flush,
  output logic [1:0]  symbol,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  sched_state_t         r_state;
  logic                 r_vsync_q;
  logic [1:0]           r_symbol;
  logic [7:0]           r_hold;
  logic [15:0]          r_frame_cnt;
  logic                 w_frame_start;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [ENTRY_W-1:0]   w_rdata;
  sym_req_t             w_head;
  sym_req_t             w_wentry;

  assign w_frame_start = r_vsync_q && !vsync;
  assign w_empty       = (w_count == '0);
  assign req_ready     = (w_count != FULL_CNT);
  assign w_push        = req_valid && req_ready && !flush;
  // Pop only when the active entry has finished (or none is active).
  assign w_pop         = w_frame_start && !flush && !w_empty &&
                         ((r_state == ST_IDLE) || (r_hold == 8'd0));
  assign w_head        = sym_req_t'(w_rdata);
  assign w_wentry      = '{sym: req_symbol, frames: req_frames};

  assign symbol    = r_symbol;
  assign busy      = (r_state == ST_SHOW);
  assign frame_cnt = r_frame_cnt;

  sym_req_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .dclk    (dclk),
    .clr     (clr),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wentry),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_vsync_q   <= 1'b1;
      r_frame_cnt <= '0;
    end else begin
      r_vsync_q <= vsync;
      if (w_frame_start) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_symbol <= IDLE_SYMBOL;
      r_hold   <= '0;
    end else if (flush) begin
      r_state  <= ST_IDLE;
      r_symbol <= IDLE_SYMBOL;
      r_hold   <= '0;
    end else if (w_frame_start) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_symbol <= w_head.sym;
            r_hold   <= hold_load(w_head.frames);
            r_state  <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (r_hold != 8'd0) begin
            r_hold <= r_hold - 8'd1;
          end else if (!w_empty) begin
            r_symbol <= w_head.sym;
            r_hold   <= hold_load(w_head.frames);
          end else begin
            r_symbol <= IDLE_SYMBOL;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_scheduler.sv
// Scoreboard bench for symbol_scheduler: each issued frame start queues the
// expected {busy, symbol}; a forked monitor pops and compares after the edge.
module tb_symbol_scheduler;
  import symbol_scheduler_pkg::*;

  logic        dclk = 1'b0;
  logic        clr;
  logic        vsync;
  logic        req_valid;
  logic [1:0]  req_symbol;
  logic [7:0]  req_frames;
  logic        req_ready;
  logic        flush;
  logic [1:0]  symbol;
  logic        busy;
  logic [15:0] frame_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          frames_issued = 0;
  int          frames_checked = 0;
  logic [2:0]  exp_q[$];
  logic [1:0]  stable_exp = 2'd0;
  bit          stable_en = 1'b0;

  symbol_scheduler #(.DEPTH(4), .IDLE_SYMBOL(SYM_GREEN)) dut (
    .dclk       (dclk),
    .clr        (clr),
    .vsync      (vsync),
    .req_valid  (req_valid),
    .req_symbol (req_symbol),
    .req_frames (req_frames),
    .req_ready  (req_ready),
    .flush      (flush),
    .symbol     (symbol),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 dclk = ~dclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One frame-period slot: optional frame start, push and flush in the same cycle.
  task automatic drive(input bit fs, input bit pv, input bit fl,
                       input logic [1:0] ps, input logic [7:0] pf,
                       input logic [1:0] es, input bit eb);
    if (fs) exp_q.push_back({eb, es});
    @(negedge dclk);
    vsync      = ~fs;
    req_valid  = pv;
    req_symbol = ps;
    req_frames = pf;
    flush      = fl;
    @(negedge dclk);
    vsync     = 1'b1;
    req_valid = 1'b0;
    flush     = 1'b0;
    if (fs) begin
      frames_issued++;
      stable_exp = es;
    end else if (fl) begin
      stable_exp = SYM_GREEN;
    end
    repeat (3) @(negedge dclk);
  endtask

  task automatic frame(input logic [1:0] es, input bit eb);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, es, eb);
  endtask

  task automatic push(input logic [1:0] s, input logic [7:0] f);
    drive(1'b0, 1'b1, 1'b0, s, f, 2'd0, 1'b0);
  endtask

  task automatic monitor();
    logic [2:0] e;
    forever begin
      @(negedge dclk);
      #1;
      if (frames_issued != frames_checked) begin
        frames_checked = frames_issued;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_underflow: got frame %0d, expected none queued", frames_issued);
        end else begin
          e = exp_q.pop_front();
          check("frame_symbol", 32'(symbol), 32'(e[1:0]));
          check("frame_busy", 32'(busy), 32'(e[2]));
        end
      end else if (stable_en) begin
        check("symbol_stable_midframe", 32'(symbol), 32'(stable_exp));
      end
    end
  endtask

  initial begin
    clr        = 1'b1;
    vsync      = 1'b1;
    req_valid  = 1'b0;
    req_symbol = 2'd0;
    req_frames = 8'd0;
    flush      = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge dclk);
    check("reset_symbol", 32'(symbol), 32'(SYM_GREEN));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    clr       = 1'b0;
    stable_en = 1'b1;
    repeat (2) @(negedge dclk);
    check("no_spurious_frame", 32'(frame_cnt), 32'd0);

    // single request {3,2}
    push(SYM_DIAMOND, 8'd2);
    frame(SYM_DIAMOND, 1'b1);
    frame(SYM_DIAMOND, 1'b1);
    frame(SYM_GREEN, 1'b0);
    check("frame_cnt_after_single", 32'(frame_cnt), 32'd3);

    // back-to-back {1,1},{2,0},{3,3}
    push(SYM_RECT, 8'd1);
    push(SYM_RED, 8'd0);
    push(SYM_DIAMOND, 8'd3);
    frame(SYM_RECT, 1'b1);
    frame(SYM_RED, 1'b1);
    frame(SYM_DIAMOND, 1'b1);
    frame(SYM_DIAMOND, 1'b1);
    frame(SYM_DIAMOND, 1'b1);
    frame(SYM_GREEN, 1'b0);
    frame(SYM_GREEN, 1'b0);

    // full FIFO: 5th push dropped
    push(SYM_GREEN, 8'd1);
    push(SYM_RECT, 8'd1);
    push(SYM_RED, 8'd1);
    check("ready_three_queued", 32'(req_ready), 32'd1);
    push(SYM_DIAMOND, 8'd1);
    check("ready_full", 32'(req_ready), 32'd0);
    push(SYM_RECT, 8'd5);
    check("ready_still_full", 32'(req_ready), 32'd0);
    frame(SYM_GREEN, 1'b1);
    check("ready_after_pop", 32'(req_ready), 32'd1);
    frame(SYM_RECT, 1'b1);
    frame(SYM_RED, 1'b1);
    frame(SYM_DIAMOND, 1'b1);
    frame(SYM_GREEN, 1'b0);

    // push coinciding with frame start on empty FIFO waits a frame
    drive(1'b1, 1'b1, 1'b0, SYM_RED, 8'd1, SYM_GREEN, 1'b0);
    frame(SYM_RED, 1'b1);
    frame(SYM_GREEN, 1'b0);

    // simultaneous push and pop
    push(SYM_RECT, 8'd1);
    push(SYM_RED, 8'd1);
    frame(SYM_RECT, 1'b1);
    drive(1'b1, 1'b1, 1'b0, SYM_DIAMOND, 8'd1, SYM_RED, 1'b1);
    frame(SYM_DIAMOND, 1'b1);
    frame(SYM_GREEN, 1'b0);

    // flush mid-SHOW with queued entries, simultaneous push and frame start
    push(SYM_RECT, 8'd3);
    push(SYM_RED, 8'd1);
    push(SYM_DIAMOND, 8'd1);
    frame(SYM_RECT, 1'b1);
    drive(1'b1, 1'b1, 1'b1, SYM_RED, 8'd2, SYM_GREEN, 1'b0);
    check("flush_symbol", 32'(symbol), 32'(SYM_GREEN));
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_req_ready", 32'(req_ready), 32'd1);
    frame(SYM_GREEN, 1'b0);
    frame(SYM_GREEN, 1'b0);
    frame(SYM_GREEN, 1'b0);
    check("frame_cnt_ignores_flush", 32'(frame_cnt), 32'd27);

    // asynchronous reset mid-SHOW
    push(SYM_RED, 8'd5);
    push(SYM_RECT, 8'd1);
    frame(SYM_RED, 1'b1);
    @(negedge dclk);
    #2;
    clr        = 1'b1;
    stable_exp = SYM_GREEN;
    #1;
    check("async_reset_symbol", 32'(symbol), 32'(SYM_GREEN));
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check("async_reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge dclk);
    clr = 1'b0;
    frame(SYM_GREEN, 1'b0);
    frame(SYM_GREEN, 1'b0);
    check("frame_cnt_after_reset", 32'(frame_cnt), 32'd2);

    // frame counter wrap, preloaded near the top
    @(negedge dclk);
    force dut.r_frame_cnt = 16'hFFFE;
    @(negedge dclk);
    release dut.r_frame_cnt;
    #1;
    check("frame_cnt_preload", 32'(frame_cnt), 32'hFFFE);
    frame(SYM_GREEN, 1'b0);
    check("frame_cnt_max", 32'(frame_cnt), 32'hFFFF);
    frame(SYM_GREEN, 1'b0);
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

    repeat (4) @(negedge dclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
